// File: rtl/clock_switch_ctrl_if.sv
// Request handshake between the clock management register block (master)
// and clock_switch_ctrl (slave).
interface clock_switch_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_sel;

  modport master (output req_valid, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/clock_switch_ctrl.sv
// Sequencer for the glitch-free two-clock switch, running on the always-on RC clock.
// Define CLK_SW_FAILSAFE_EN to enable forced fallback to RC on loss of oscillator.
module clock_switch_ctrl #(
  parameter int unsigned WARMUP_CYCLES  = 1024,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic               clk,
  input  logic               rst,
  clock_switch_ctrl_if.slave req,
  input  logic               osc_good,
  input  logic               fault_clr,
  output logic               osc_en,
  output logic               sel_clk1,
  output logic               cur_sel,
  output logic               done,
  output logic               fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             tgt_q, tgt_d;
  logic             osc_en_q, osc_en_d;
  logic             sel_q, sel_d;
  logic             cur_q, cur_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic accept;
  logic stable_hit;
  logic tmo_hit;
  logic settle_hit;
  logic failsafe;

  assign req.req_ready = (state_q == S_IDLE);

  assign accept     = req.req_valid && (state_q == S_IDLE);
  assign stable_hit = (state_q == S_WARMUP) && osc_good && (cnt_q == WARM_LAST);
  assign tmo_hit    = (state_q == S_WARMUP) && (tmo_q == TMO_LAST);
  assign settle_hit = (state_q == S_SETTLE) && (cnt_q == SETTLE_LAST);

`ifdef CLK_SW_FAILSAFE_EN
  // Fallback overrides any request accepted in the same cycle.
  assign failsafe = !osc_good &&
                    (((state_q == S_IDLE) && cur_q) || ((state_q == S_SETTLE) && tgt_q));
`else
  assign failsafe = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      tgt_q    <= 1'b0;
      osc_en_q <= 1'b0;
      sel_q    <= 1'b0;
      cur_q    <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      tgt_q    <= tgt_d;
      osc_en_q <= osc_en_d;
      sel_q    <= sel_d;
      cur_q    <= cur_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  // The stable count and the settle count share cnt_q; they are never live together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    tgt_d   = tgt_q;
    if (failsafe) begin
      state_d = S_SETTLE;
      cnt_d   = '0;
      tgt_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            tgt_d = req.req_sel;
            if (req.req_sel != cur_q) begin
              cnt_d   = '0;
              tmo_d   = '0;
              state_d = req.req_sel ? S_WARMUP : S_SETTLE;
            end
          end
        end
        S_WARMUP: begin
          tmo_d = tmo_q + 1'b1;
          cnt_d = osc_good ? cnt_q + 1'b1 : '0;
          if (stable_hit) begin
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else if (tmo_hit) begin
            state_d = S_IDLE;
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q + 1'b1;
          if (settle_hit) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    osc_en_d = osc_en_q;
    sel_d    = sel_q;
    cur_d    = cur_q;
    done_d   = 1'b0;
    fault_d  = fault_clr ? 1'b0 : fault_q;
    if (failsafe) begin
      sel_d   = 1'b0;
      fault_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (req.req_sel == cur_q) begin
              done_d = 1'b1;
            end else if (req.req_sel) begin
              osc_en_d = 1'b1;
            end else begin
              sel_d = 1'b0;
            end
          end
        end
        S_WARMUP: begin
          if (stable_hit) begin
            sel_d = 1'b1;
          end else if (tmo_hit) begin
            osc_en_d = 1'b0;
            fault_d  = 1'b1;
            done_d   = 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_hit) begin
            cur_d  = tgt_q;
            done_d = 1'b1;
            if (!tgt_q) begin
              osc_en_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign osc_en   = osc_en_q;
  assign sel_clk1 = sel_q;
  assign cur_sel  = cur_q;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Scoreboard bench for clock_switch_ctrl (W=8, S=4, T=32): expected output events
// are queued per signal at request time and matched by an independent monitor.
module tb_clock_switch_ctrl;

  localparam int OSC = 0;
  localparam int SEL = 1;
  localparam int CUR = 2;
  localparam int FLT = 3;
  localparam int DON = 4;
  localparam int RDY = 5;

  typedef struct {
    int unsigned cyc;
    logic        val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic osc_good;
  logic fault_clr;
  logic osc_en;
  logic sel_clk1;
  logic cur_sel;
  logic done;
  logic fault;

  clock_switch_ctrl_if rif ();

  clock_switch_ctrl #(
    .WARMUP_CYCLES (8),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(32),
    .CNT_W         (13)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (rif.slave),
    .osc_good (osc_good),
    .fault_clr(fault_clr),
    .osc_en   (osc_en),
    .sel_clk1 (sel_clk1),
    .cur_sel  (cur_sel),
    .done     (done),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  int unsigned ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int   vectors = 0;
  int   errs    = 0;
  ev_t  evq [6][$];
  logic mon_en  = 1'b0;
  logic [5:0] mon_now;
  logic [5:0] mon_prev = '0;
  ev_t  mon_e;

  function automatic string sname(input int i);
    case (i)
      OSC:     return "osc_en";
      SEL:     return "sel_clk1";
      CUR:     return "cur_sel";
      FLT:     return "fault";
      DON:     return "done";
      default: return "req_ready";
    endcase
  endfunction

  // done is checked on every high cycle; the other outputs on every change.
  always @(negedge clk) begin
    mon_now = {rif.req_ready, done, fault, cur_sel, sel_clk1, osc_en};
    if (mon_en) begin
      for (int i = 0; i < 6; i++) begin
        if ((i == DON) ? mon_now[i] : (mon_now[i] != mon_prev[i])) begin
          vectors++;
          if (evq[i].size() == 0) begin
            errs++;
            $display("FAIL %s: got unexpected %0b at cycle %0d, required no change",
                     sname(i), mon_now[i], ecnt);
          end else begin
            mon_e = evq[i].pop_front();
            if (mon_e.cyc != ecnt || mon_e.val != mon_now[i]) begin
              errs++;
              $display("FAIL %s: got %0b at cycle %0d, required %0b at cycle %0d",
                       sname(i), mon_now[i], ecnt, mon_e.val, mon_e.cyc);
            end
          end
        end
      end
    end
    mon_prev = mon_now;
  end

  task automatic chk(input string nm, input logic act, input logic rq);
    vectors++;
    if (act !== rq) begin
      errs++;
      $display("FAIL %s: got %0b, required %0b", nm, act, rq);
    end
  endtask

  task automatic chk_int(input string nm, input int unsigned act, input int unsigned rq);
    vectors++;
    if (act != rq) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", nm, act, rq);
    end
  endtask

  // Expect signal sig to show value v in cycle n counted from acceptance edge a.
  task automatic ex(input int sig, input int unsigned a, input int unsigned n, input logic v);
    evq[sig].push_back(ev_t'{a + n - 1, v});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 6; i++) if (evq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Called at a negedge; returns the edge at which the request will be accepted.
  task automatic send(input logic s, output int unsigned a);
    rif.req_valid = 1'b1;
    rif.req_sel   = s;
    a = 0;
    for (int k = 0; k < 100; k++) begin
      if (rif.req_ready) begin
        a = ecnt + 1;
        return;
      end
      @(negedge clk);
    end
    vectors++;
    errs++;
    $display("FAIL accept: got req_ready low for 100 cycles, required acceptance");
  endtask

  task automatic release_req();
    @(negedge clk);
    rif.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (all_empty()) break;
      @(negedge clk);
    end
    vectors++;
    if (!all_empty()) begin
      errs++;
      $display("FAIL %s: got expected events still pending after %0d cycles, required none", nm, bound);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned a, a2, e;
    rst           = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_sel   = 1'b0;
    osc_good      = 1'b0;
    fault_clr     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_osc_en", osc_en, 1'b0);
    chk("rst_sel_clk1", sel_clk1, 1'b0);
    chk("rst_cur_sel", cur_sel, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_req_ready", rif.req_ready, 1'b1);
    mon_en   = 1'b1;
    osc_good = 1'b1;

    // RC -> oscillator, osc_good steady
    send(1'b1, a);
    ex(OSC, a, 1, 1'b1);  ex(RDY, a, 1, 1'b0);  ex(SEL, a, 9, 1'b1);
    ex(DON, a, 13, 1'b1); ex(CUR, a, 13, 1'b1); ex(RDY, a, 13, 1'b1);
    release_req();
    drain("rc_to_osc", 100);

    // Oscillator -> RC
    send(1'b0, a);
    ex(SEL, a, 1, 1'b0); ex(RDY, a, 1, 1'b0);
    ex(DON, a, 5, 1'b1); ex(CUR, a, 5, 1'b0); ex(OSC, a, 5, 1'b0); ex(RDY, a, 5, 1'b1);
    release_req();
    drain("osc_to_rc", 50);

    // Glitchy oscillator: osc_good low only during cycle 5
    send(1'b1, a);
    ex(OSC, a, 1, 1'b1);  ex(RDY, a, 1, 1'b0);  ex(SEL, a, 14, 1'b1);
    ex(DON, a, 18, 1'b1); ex(CUR, a, 18, 1'b1); ex(RDY, a, 18, 1'b1);
    release_req();
    repeat (4) @(negedge clk);
    osc_good = 1'b0;
    @(negedge clk);
    osc_good = 1'b1;
    drain("glitchy", 100);
    chk("glitchy_fault", fault, 1'b0);

    // Held request during SETTLE is taken on the done cycle (then a no-op)
    send(1'b0, a);
    ex(SEL, a, 1, 1'b0); ex(RDY, a, 1, 1'b0);
    ex(DON, a, 5, 1'b1); ex(CUR, a, 5, 1'b0); ex(OSC, a, 5, 1'b0); ex(RDY, a, 5, 1'b1);
    @(negedge clk);
    send(1'b0, a2);
    chk_int("held_accept_edge", a2, a + 5);
    ex(DON, a2, 1, 1'b1);
    release_req();
    drain("held_req", 50);

    // Warm-up timeout
    osc_good = 1'b0;
    send(1'b1, a);
    ex(OSC, a, 1, 1'b1);  ex(RDY, a, 1, 1'b0);
    ex(FLT, a, 33, 1'b1); ex(DON, a, 33, 1'b1); ex(OSC, a, 33, 1'b0); ex(RDY, a, 33, 1'b1);
    release_req();
    drain("timeout", 100);
    chk("timeout_cur_sel", cur_sel, 1'b0);
    @(negedge clk);
    fault_clr = 1'b1;
    ex(FLT, ecnt + 1, 1, 1'b0);
    @(negedge clk);
    fault_clr = 1'b0;
    drain("fault_clr", 10);

    // Same-selection request: done only
    send(1'b0, a);
    ex(DON, a, 1, 1'b1);
    release_req();
    drain("noop", 10);

    // Back to the oscillator, then lose it while idle
    osc_good = 1'b1;
    send(1'b1, a);
    ex(OSC, a, 1, 1'b1);  ex(RDY, a, 1, 1'b0);  ex(SEL, a, 9, 1'b1);
    ex(DON, a, 13, 1'b1); ex(CUR, a, 13, 1'b1); ex(RDY, a, 13, 1'b1);
    release_req();
    drain("rc_to_osc_2", 100);
    @(negedge clk);
    osc_good = 1'b0;
    e = ecnt;
`ifdef CLK_SW_FAILSAFE_EN
    ex(SEL, e + 1, 1, 1'b0); ex(FLT, e + 1, 1, 1'b1); ex(RDY, e + 1, 1, 1'b0);
    ex(DON, e + 1, 5, 1'b1); ex(CUR, e + 1, 5, 1'b0); ex(OSC, e + 1, 5, 1'b0);
    ex(RDY, e + 1, 5, 1'b1);
`endif
    @(negedge clk);
    osc_good = 1'b1;
    repeat (8) @(negedge clk);
    drain("osc_loss", 20);
`ifdef CLK_SW_FAILSAFE_EN
    chk("osc_loss_cur_sel", cur_sel, 1'b0);
    chk("osc_loss_fault", fault, 1'b1);
`else
    chk("osc_loss_sel_clk1", sel_clk1, 1'b1);
    chk("osc_loss_cur_sel", cur_sel, 1'b1);
    chk("osc_loss_fault", fault, 1'b0);
`endif

    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) chk_int({"leftover_", sname(i)}, evq[i].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
